dpram: RTL and testbench

DPRAM -- requirements
Module: dpram

---
 rtl/dpram.sv | 149 ++++++++++++++
 tb/tb_dpram.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dpram.sv
// dpram -- true dual-port RAM with valid/ready handshake, single clock.
//
// Ports
//   clk             rising-edge clock for all state
//   rst_n           synchronous active-low reset
//   addr_a/addr_b   word address per port
//   data_a/data_b   write data per port
//   we_a/we_b       1 = write, 0 = read (qualified by valid)
//   valid_a/valid_b request present
//   ready_a/ready_b request accepted this cycle (combinational)
//   q_a/q_b         registered read data, held until next accepted read
//
// Port A always wins an address conflict (same address, at least one write);
// port B is stalled via ready_b until the conflict clears. Addresses at or
// above DEPTH are dropped on write and read back as zero.
//
// Build option: define DPRAM_RESET_CLEAR_EN to zero every memory word on each
// reset edge. Undefined (default): memory content survives reset.

// Per-port request decode: acceptance, write/read enables, range check.
module dpram_port #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic                  we,
  input  logic                  ready,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic                  in_rng
);
  logic acc;

  always_comb begin
    // Requests seen on a reset edge are discarded even if init_done is
    // still high from before the reset.
    acc    = valid & ready & rst_n;
    in_rng = (32'(addr) < DEPTH);
    wr_en  = acc & we & in_rng;
    rd_en  = acc & ~we;
  end
endmodule

module dpram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic                  valid_a,
  input  logic                  valid_b,
  output logic                  ready_a,
  output logic                  ready_b,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b
);
  localparam int NP = 2;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                  vld;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  req_t [NP-1:0]                 req;
  logic [NP-1:0]                 rdy;
  logic [NP-1:0]                 wr_en;
  logic [NP-1:0]                 rd_en;
  logic [NP-1:0]                 in_rng;
  logic [NP-1:0][DATA_WIDTH-1:0] q_r;

  logic                  init_done;
  logic                  conflict;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign req[0] = '{vld: valid_a, we: we_a, addr: addr_a, data: data_a};
  assign req[1] = '{vld: valid_b, we: we_b, addr: addr_b, data: data_b};

  // Same-address pair with any write: B yields. Two reads never conflict.
  assign conflict = valid_a & valid_b & (addr_a == addr_b) & (we_a | we_b);
  assign rdy[0]   = init_done;
  assign rdy[1]   = init_done & ~conflict;
  assign ready_a  = rdy[0];
  assign ready_b  = rdy[1];
  assign q_a      = q_r[0];
  assign q_b      = q_r[1];

  for (genvar p = 0; p < NP; p++) begin : g_port
    dpram_port #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH     (DEPTH)
    ) u_port (
      .rst_n (rst_n),
      .valid (req[p].vld),
      .we    (req[p].we),
      .ready (rdy[p]),
      .addr  (req[p].addr),
      .wr_en (wr_en[p]),
      .rd_en (rd_en[p]),
      .in_rng(in_rng[p])
    );
  end

  // init_done drops on every reset edge and rises on the first free edge,
  // so ready appears one cycle after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  // Both ports can write in the same cycle only to different addresses,
  // so loop order never decides a winner.
`ifdef DPRAM_RESET_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int p = 0; p < NP; p++)
        if (wr_en[p]) mem[req[p].addr[MW-1:0]] <= req[p].data;
    end
  end
`else
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++)
      if (wr_en[p]) mem[req[p].addr[MW-1:0]] <= req[p].data;
  end
`endif

  // Read data: loaded only on an accepted read, otherwise held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r <= '0;
    end else begin
      for (int p = 0; p < NP; p++)
        if (rd_en[p]) q_r[p] <= in_rng[p] ? mem[req[p].addr[MW-1:0]] : '0;
    end
  end
endmodule

// File: tb/tb_dpram.sv
module tb_dpram;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 240;  // leaves 240..255 out of range

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic          we_a = 1'b0, we_b = 1'b0, valid_a = 1'b0, valid_b = 1'b0;
  logic          ready_a, ready_b;
  logic [DW-1:0] q_a, q_b;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [DW-1:0] mdl_mem [DEPTH];
  logic [DW-1:0] mq_a, mq_b;
  logic          minit;

  dpram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_a(addr_a), .addr_b(addr_b),
    .data_a(data_a), .data_b(data_b),
    .we_a(we_a), .we_b(we_b),
    .valid_a(valid_a), .valid_b(valid_b),
    .ready_a(ready_a), .ready_b(ready_b),
    .q_a(q_a), .q_b(q_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check ready combinationally, update
  // the reference at the edge, check q just after the edge.
  task automatic step(input logic va, input logic wa, input logic [AW-1:0] aa,
                      input logic [DW-1:0] da, input logic vb, input logic wb,
                      input logic [AW-1:0] ab, input logic [DW-1:0] db);
    logic cf, ra, rb;
    logic [DW-1:0] rd_a, rd_b;
    valid_a = va; we_a = wa; addr_a = aa; data_a = da;
    valid_b = vb; we_b = wb; addr_b = ab; data_b = db;
    #1;
    cf = va && vb && (aa == ab) && (wa || wb);
    ra = minit;
    rb = minit && !cf;
    chk("ready_a", ready_a, ra);
    chk("ready_b", ready_b, rb);
    @(posedge clk);
    if (!rst_n) begin
      mq_a = '0; mq_b = '0; minit = 1'b0;
`ifdef DPRAM_RESET_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
`endif
    end else begin
      rd_a = (int'(aa) < DEPTH) ? mdl_mem[aa] : '0;
      rd_b = (int'(ab) < DEPTH) ? mdl_mem[ab] : '0;
      if (va && ra && !wa) mq_a = rd_a;
      if (vb && rb && !wb) mq_b = rd_b;
      if (va && ra && wa && int'(aa) < DEPTH) mdl_mem[aa] = da;
      if (vb && rb && wb && int'(ab) < DEPTH) mdl_mem[ab] = db;
      minit = 1'b1;
    end
    #1;
    chk("q_a", q_a, mq_a);
    chk("q_b", q_b, mq_b);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [AW-1:0] ra_, rb_;
    // First edge brings the DUT out of its unknown power-up state.
    @(posedge clk);
    @(negedge clk);
    minit = 1'b0; mq_a = '0; mq_b = '0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    for (int i = 0; i < 4; i++) idle();
    chk("rst_q_a", q_a, 32'h0);
    chk("rst_q_b", q_b, 32'h0);

    // Release: not ready in the first cycle, ready afterwards.
    rst_n = 1'b1;
    idle();
    chk("rdy_a_after_rel", ready_a, 32'h1);
    chk("rdy_b_after_rel", ready_b, 32'h1);

    // Fill every in-range word so later reads are fully defined.
    for (int i = 0; i < DEPTH / 2; i++)
      step(1'b1, 1'b1, AW'(i), DW'($urandom), 1'b1, 1'b1, AW'(i + DEPTH / 2), DW'($urandom));

    // Write then read on port A.
    step(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, '0, '0);
    chk("wr_rd_a", q_a, 32'hA5);

    // Concurrent writes to different addresses, then crossed reads.
    step(1'b1, 1'b1, 8'h20, 8'h11, 1'b1, 1'b1, 8'h21, 8'h22);
    step(1'b1, 1'b0, 8'h21, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    chk("cross_q_b", q_b, 32'h11);
    chk("cross_q_a", q_a, 32'h22);

    // Write/write conflict: B stalls one cycle, then lands last.
    step(1'b1, 1'b1, 8'h30, 8'h33, 1'b1, 1'b1, 8'h30, 8'h44);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h30, 8'h44);
    step(1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, '0, '0);
    chk("conflict_final", q_a, 32'h44);

    // Same-address dual read is not a conflict.
    step(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    chk("dual_rd_a", q_a, 32'hA5);
    chk("dual_rd_b", q_b, 32'hA5);

    // Out-of-range: write dropped, read returns zero.
    step(1'b1, 1'b1, 8'hF5, 8'h77, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 8'hF5, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00);
    chk("oor_q_a", q_a, 32'h0);
    chk("oor_q_b", q_b, 32'h0);

    // Memory across reset.
    step(1'b1, 1'b1, 8'h40, 8'h5A, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 8'h40, 8'h99, 1'b1, 1'b0, 8'h40, 8'h00);  // ignored
    idle();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, '0, '0);  // not ready yet
    step(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, '0, '0);
`ifdef DPRAM_RESET_CLEAR_EN
    chk("mem_after_rst", q_a, 32'h00);
`else
    chk("mem_after_rst", q_a, 32'h5A);
`endif

    // Randomized traffic around a small hot set and the range boundary,
    // with occasional resets dropped in.
    for (int n = 0; n < 600; n++) begin
      ra_ = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(DEPTH - 4, DEPTH + 3));
      rb_ = $urandom_range(0, 2) == 0 ? ra_ : AW'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 39) != 0);
      step(1'($urandom), 1'($urandom), ra_, DW'($urandom),
           1'($urandom), 1'($urandom), rb_, DW'($urandom));
    end
    rst_n = 1'b1;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
